uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that acts as the responder for CPU data-memory load and store accesses in the peripheral address range. A store to the TX data register queues a byte in a small FIFO. An FSM then serialises the queued bytes, 8N1, LSB first, on the tx pin. The CPU polls a status register to see whether the FIFO is full and whether the transmitter is busy.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 9600, serial bit rate.
FIFO_DEPTH, 4, TX FIFO entries; must be a power of two and at least 2.
TXD_ADDR, 32'h40000018, address of the TX data register (write-only; bits [7:0] are used).
STAT_ADDR, 32'h40000020, address of the status register (read-only).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
mem_write  input  1  CPU store strobe, valid for one cycle per access.
mem_read  input  1  CPU load strobe.
addr  input  32  CPU byte address.
wdata  input  32  CPU store data.
rdata  output  32  load data; combinational from addr and mem_read.
tx  output  1  serial line; idles high.
irq  output  1  level interrupt, high while the FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, irq=1.
  - FIFO pointers and count = 0.
  - FSM = IDLE; baud counter = 0; bit index = 0.
  - rdata is 0 unless a status read is presented.
- Baud timing:
  - DIV = CLK_FREQ/BAUD, integer division.
  - The baud counter runs from 0 to DIV-1 while the FSM is not IDLE. The final count is the bit tick.
  - Each serial bit is held for exactly DIV cycles.
- Write path:
  - A push occurs when mem_write=1, addr==TXD_ADDR and the FIFO is not full. wdata[7:0] is pushed.
  - A write while the FIFO is full is dropped silently. A sticky overflow flag is set and is cleared only by reset.
  - Writes to any other address are ignored.
- Status register, returned when mem_read=1 and addr==STAT_ADDR:
  - bit0 = busy (FSM not IDLE).
  - bit1 = full.
  - bit2 = empty.
  - bit3 = overflow.
  - bits[7:4] = FIFO count, zero-extended.
  - bits[31:8] = 0.
- Any other read returns 0. Reads have no side effects.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If the FIFO is not empty, pop the head into the shift register, clear the baud counter and go to START on the next cycle.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles. Then shift right and increment the bit index. After index 7, go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
  - From IDLE with the FIFO non-empty, the next START begins on the following cycle, so one extra idle cycle separates frames.
- Latency: a push into an empty FIFO with the FSM in IDLE produces the tx falling edge 2 cycles after the write edge (1 cycle for the push, 1 for the pop/transition).
- Simultaneous push and pop in the same cycle are both performed and the count is unchanged. A full FIFO with a pop in that cycle accepts the push.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-frame aborts the frame: tx returns to 1 immediately (asynchronously) and FIFO contents are discarded.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: the frame is 8E1. A PARITY state is inserted between DATA and STOP, in which tx = XOR of the 8 data bits (even parity) for DIV cycles. The frame is 11 bit-times.
- Not defined: there is no PARITY state and the frame is 10 bit-times.

Test Plan:
- All four tests use CLK_FREQ=100 and BAUD=10, so DIV=10.
- Reset: hold rst=0 with random bus activity -> tx=1, irq=1, status read = 32'h00000004. Release rst -> values unchanged.
- Single byte: store 32'h000000A5 to 32'h40000018 -> tx falls 2 cycles later. Serial sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit held 10 cycles. busy=1 throughout; irq=1 after the stop bit.
- FIFO full/overflow: 5 back-to-back stores of 11,22,33,44,55, with the first pop occurring during the writes -> status shows full=1 and overflow=0. A 6th store -> overflow=1 and is dropped. The line carries exactly 5 frames in order (4 without an early pop), then empty=1.
- Push/pop collision: with the FIFO full and the FSM about to pop in IDLE, issue a store in the same cycle -> count stays at 4 and no overflow flag is set.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 immediately; after release, status = 32'h00000004 and no residual frame appears.
- Parity (UART_TX_PARITY_EN defined): send 32'h07 -> parity bit = 1 before the stop bit, and the frame is 110 cycles. Without the macro -> the frame is 100 cycles.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined) with a small TX FIFO and status register.
// Ports: clk, rst (async active-low), mem_write, mem_read, addr[31:0],
//        wdata[31:0] in; rdata[31:0] (comb status read), tx, irq out.
module uart_tx_mmio #(
    parameter int          CLK_FREQ   = 100000000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] TXD_ADDR   = 32'h40000018,
    parameter logic [31:0] STAT_ADDR  = 32'h40000020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_n;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    logic tick, pop, push, wr_hit, full, empty, busy;

    // Only the low byte of a store is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign busy   = (state != IDLE);
    assign tick   = (cnt == LAST_CNT);
    assign wr_hit = mem_write && (addr == TXD_ADDR);
    // A same-cycle pop frees a slot, so a full FIFO still accepts.
    assign push   = wr_hit && (!full || pop);
    assign irq    = empty && !busy;

    always_comb begin
        rdata = '0;
        if (mem_read && addr == STAT_ADDR) begin
            rdata = {24'b0, 4'(count), overflow, empty, full, busy};
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx      = 1'b1;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) state_n = DATA;
            end
            DATA: begin
                tx = shift[0];
                if (tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (tick) state_n = STOP;
            end
`endif
            STOP: begin
                if (tick) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + 1'b1;
            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^mem[rd_ptr];
`endif
            end else if (state == DATA && tick) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (wr_hit && !push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with a frame-level
// reference model, a line decoder and hand-computed literal checks.
module tb_uart_tx_mmio;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int F         = 11;
    localparam int FRAME_CYC = 110;
`else
    localparam int F         = 10;
    localparam int FRAME_CYC = 100;
`endif
    localparam logic [31:0] TXD  = 32'h40000018;
    localparam logic [31:0] STAT = 32'h40000020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx, irq;

    uart_tx_mmio #(
        .CLK_FREQ(100), .BAUD(10), .FIFO_DEPTH(4),
        .TXD_ADDR(TXD), .STAT_ADDR(STAT)
    ) dut (
        .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
        .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: byte queue, sticky overflow, current frame start.
    logic [7:0] q[$];
    bit         m_ovf = 0;
    bit         fv = 0;
    int         fs = 0;
    int         cyc = 0;
    logic [7:0] fb = '0;
    int         mn;
    bit         m_busy_prev, m_pop, m_full;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ovf = 0;
            fv    = 0;
        end else begin
            mn          = cyc + 1;
            m_busy_prev = fv && (mn - 1 - fs) < F * DIV;
            m_pop       = !m_busy_prev && q.size() > 0;
            m_full      = q.size() == 4;
            if (m_pop) begin
                fb = q.pop_front();
                fs = mn;
                fv = 1;
            end
            if (mem_write && addr == TXD) begin
                if (!m_full || m_pop) q.push_back(wdata[7:0]);
                else m_ovf = 1;
            end
            cyc = mn;
        end
    end

    function automatic bit in_frame();
        return fv && (cyc - fs) < F * DIV;
    endfunction

    function automatic logic exp_tx();
        int b;
        if (!in_frame()) return 1'b1;
        b = (cyc - fs) / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return fb[b-1];
        if (F == 11 && b == 9) return ^fb;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!(mem_read && addr == STAT)) return 32'h0;
        return {24'b0, 4'(q.size()), m_ovf, q.size() == 0,
                q.size() == 4, in_frame()};
    endfunction

    always @(negedge clk) begin
        #2;
        chk("model_tx", {31'b0, tx}, {31'b0, exp_tx()});
        chk("model_irq", {31'b0, irq}, {31'b0, !in_frame() && q.size() == 0});
        chk("model_rdata", rdata, exp_rd());
    end

    // Line decoder sampling mid-bit.
    logic [7:0] rxq[$];
    logic       rxp[$];
    logic [7:0] rxb;

    initial forever begin
        @(negedge clk);
        if (rst === 1'b1 && tx === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                rxb[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (DIV) @(negedge clk);
            rxp.push_back(tx);
`endif
            repeat (DIV) @(negedge clk);
            rxq.push_back(rxb);
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
    endtask

    task automatic rd(output logic [31:0] v);
        mem_read = 1'b1;
        addr     = STAT;
        #3;
        v        = rdata;
        mem_read = 1'b0;
        addr     = '0;
        @(negedge clk);
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'b0, irq}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] v;
    int          seq[11];
    int          n;

    initial begin
`ifdef UART_TX_PARITY_EN
        seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        // Reset with bus noise
        repeat (8) begin
            @(negedge clk);
            mem_write = 1'($urandom % 2);
            mem_read  = 1'($urandom % 2);
            addr      = ($urandom % 2) ? TXD : STAT;
            wdata     = $urandom;
        end
        @(negedge clk);
        mem_write = 1'b0;
        rd(v);
        chk("rst_stat", v, 32'h4);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rd(v);
        chk("rel_stat", v, 32'h4);
        chk("rel_tx", {31'b0, tx}, 32'd1);
        chk("rel_irq", {31'b0, irq}, 32'd1);

        // Single byte A5
        store(TXD, 32'h000000A5);
        mem_read = 1'b1;
        addr     = STAT;
        #3 chk("pre_start_tx", {31'b0, tx}, 32'd1);
        @(negedge clk);
        #3 chk("start_edge_tx", {31'b0, tx}, 32'd0);
        repeat (5) @(negedge clk);
        #3 chk("bit0", {31'b0, tx}, 32'(seq[0]));
        for (int b = 1; b < F; b++) begin
            repeat (DIV) @(negedge clk);
            #3 chk($sformatf("bit%0d", b), {31'b0, tx}, 32'(seq[b]));
        end
        repeat (4) @(negedge clk);
        #3 chk("last_cycle_busy", rdata, 32'h5);
        @(negedge clk);
        #3 chk("after_frame_stat", rdata, 32'h4);
        chk("after_frame_irq", {31'b0, irq}, 32'd1);
        mem_read = 1'b0;
        addr     = '0;
        @(negedge clk);

        // FIFO full / overflow
        rxq.delete();
        store(TXD, 32'h11);
        store(TXD, 32'h22);
        store(TXD, 32'h33);
        store(TXD, 32'h44);
        store(TXD, 32'h55);
        rd(v);
        chk("full_stat", v, 32'h43);
        store(TXD, 32'h66);
        rd(v);
        chk("ovf_stat", v, 32'h4B);
        wait_irq(6 * F * DIV + 50);
        chk("rx5_count", 32'(rxq.size()), 32'd5);
        chk("rx5_0", {24'b0, rxq[0]}, 32'h11);
        chk("rx5_1", {24'b0, rxq[1]}, 32'h22);
        chk("rx5_2", {24'b0, rxq[2]}, 32'h33);
        chk("rx5_3", {24'b0, rxq[3]}, 32'h44);
        chk("rx5_4", {24'b0, rxq[4]}, 32'h55);
        rd(v);
        chk("drained_stat", v, 32'h0C);

        // Push/pop collision
        do_reset();
        rxq.delete();
        store(TXD, 32'h01);
        store(TXD, 32'h02);
        store(TXD, 32'h03);
        store(TXD, 32'h04);
        store(TXD, 32'h05);
        repeat (F * DIV - 3) @(negedge clk);
        store(TXD, 32'h06);
        rd(v);
        chk("collision_stat", v, 32'h43);
        wait_irq(7 * F * DIV + 50);
        chk("rx6_count", 32'(rxq.size()), 32'd6);
        chk("rx6_1", {24'b0, rxq[1]}, 32'h02);
        chk("rx6_5", {24'b0, rxq[5]}, 32'h06);
        rd(v);
        chk("collision_end_stat", v, 32'h4);

        // Reset mid-frame
        store(TXD, 32'hA5);
        @(negedge clk);
        repeat (44) @(negedge clk);
        #1 chk("bit3_tx", {31'b0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1 chk("async_rst_tx", {31'b0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd(v);
        chk("mid_rst_stat", v, 32'h4);
        repeat (120) @(negedge clk);
        rxq.delete();
        repeat (2 * F * DIV) @(negedge clk);
        chk("no_residual", 32'(rxq.size()), 32'd0);
        rd(v);
        chk("post_rst_stat", v, 32'h4);

        // Frame length / parity with 0x07
        rxq.delete();
        rxp.delete();
        store(TXD, 32'h07);
        @(negedge clk);
        n = 0;
        while (irq !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len", 32'(n), 32'(FRAME_CYC));
        repeat (2) @(negedge clk);
        chk("rx07", {24'b0, rxq[0]}, 32'h07);
`ifdef UART_TX_PARITY_EN
        chk("parity07", {31'b0, rxp[0]}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
